word_accumulator: RTL

Downstream stage of the `shift` block. It consumes the 32-bit word stream that `shift` presents on its `Shift` output, one word per accepted cycle. It sums each group of `COUNT` consecutive words into a widened result and holds that result behind a valid/ready handshake until the consumer takes it.

---
 rtl/adder_pkg.sv | 13 +
 rtl/word_accumulator.sv | 101 ++++++++++
 2 files changed

// File: rtl/adder_pkg.sv
// Shared types and defaults for the word accumulator.
// Imported by the accumulator and its bench.
package adder_pkg;

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } acc_state_t;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_COUNT = 4;

endpackage

// File: rtl/word_accumulator.sv
// Sums groups of COUNT words from the shift stage.
// Each result is held behind a valid/ready handshake.
module word_accumulator
  import adder_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int COUNT = DEFAULT_COUNT,
  localparam int SUM_W = WIDTH + $clog2(COUNT),
  localparam int CNT_W = $clog2(COUNT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] Shift,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [SUM_W-1:0] sum,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic             carry,
  output logic [CNT_W-1:0] word_cnt
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

  acc_state_t       state_q, state_d;
  logic [SUM_W-1:0] acc_q, acc_d;
  logic [SUM_W-1:0] sum_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic [SUM_W-1:0] ext;
  logic             xfer;
  logic             last;

  // Shift only enters the datapath through ext, which is used on xfer.
  assign ext  = {{(SUM_W-WIDTH){1'b0}}, Shift};
  assign xfer = in_valid & in_ready;
  assign last = (cnt_q == LAST);

  // Restart the group on word 0, otherwise keep summing.
  always_comb begin
    acc_d = acc_q + ext;
    if (cnt_q == '0) begin
      acc_d = ext;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ACC;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake outputs, decoded from state only.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    sum_valid = 1'b0;
    unique case (state_q)
      ACC: begin
        in_ready = 1'b1;
        if (in_valid && last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        sum_valid = 1'b1;
        if (sum_ready) begin
          state_d = ACC;
        end
      end
      default: state_d = ACC;
    endcase
  end

  // Accumulator, word counter and held result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else if (xfer) begin
      acc_q <= acc_d;
      if (last) begin
        cnt_q   <= '0;
        sum_q   <= acc_d;
        carry_q <= |acc_d[SUM_W-1:WIDTH];
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign sum      = sum_q;
  assign carry    = carry_q;
  assign word_cnt = cnt_q;

endmodule
